// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60Hz VGA timing generator.
// Produces the raw x/y scan position for a combinational pixel source, then
// registers that source's colour together with hsync/vsync, so colour,
// blanking and sync reach the pins aligned one pixel period behind x/y.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rgb_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pixel_tick,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb_out,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_MAX    = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_MAX    = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]   H_VIS    = H_W'(H_DISPLAY);
    localparam logic [V_W-1:0]   V_VIS    = V_W'(V_DISPLAY);
    localparam logic [H_W-1:0]   HS_FIRST = H_W'(H_DISPLAY + H_FRONT);
    localparam logic [H_W-1:0]   HS_LAST  = H_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [V_W-1:0]   VS_FIRST = V_W'(V_DISPLAY + V_FRONT);
    localparam logic [V_W-1:0]   VS_LAST  = V_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [H_W-1:0]   r_h_cnt;
    logic [V_W-1:0]   r_v_cnt;
    logic             r_hsync;
    logic             r_vsync;
    logic [2:0]       r_rgb;
    logic             r_frame_start;

    logic w_tick;
    logic w_h_end;
    logic w_v_end;
    logic w_video_on;
    logic w_hsync_n;
    logic w_vsync_n;

    assign w_tick     = (r_div_cnt == DIV_MAX);
    assign w_h_end    = (r_h_cnt == H_MAX);
    assign w_v_end    = (r_v_cnt == V_MAX);
    assign w_video_on = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign w_hsync_n  = ~((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
    assign w_vsync_n  = ~((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));

    // Clock divider: one pixel period every CLK_DIV clks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Scan position: advance one pixel per tick, v steps only on the h wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_tick) begin
            if (w_h_end) begin
                r_h_cnt <= '0;
                if (w_v_end) begin
                    r_v_cnt <= '0;
                end else begin
                    r_v_cnt <= r_v_cnt + 1'b1;
                end
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    // Output stage: sync and colour from the pre-increment position, so all pins share one pixel of lag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && w_h_end && w_v_end;
            if (w_tick) begin
                r_hsync <= w_hsync_n;
                r_vsync <= w_vsync_n;
                r_rgb   <= w_video_on ? rgb_in : 3'b000;
            end
        end
    end

    assign x           = 10'(r_h_cnt);
    assign y           = 10'(r_v_cnt);
    assign pixel_tick  = w_tick;
    assign video_on    = w_video_on;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb_out     = r_rgb;
    assign frame_start = r_frame_start;

endmodule
